data_mem_arbiter: RTL

- Shares the single-port synchronous data RAM between two requesters: the CPU MEM stage and the UART loader.
- Sits between the pipeline's MEM stage / Bus address decode and the data RAM instance.
- CPU has fixed priority, with two exceptions: an anti-starvation counter promotes the loader, and loader-exclusive mode locks the CPU out.
- Un-granted CPU accesses are held off with a pipeline stall.

---
 rtl/data_mem_arbiter_pkg.sv | 23 ++
 rtl/data_mem_arbiter_starve_counter.sv | 34 +++
 rtl/data_mem_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data RAM arbiter: FSM encoding, starvation
// counter sizing and the byte-to-word address helper.
package data_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        LDR_RD = 2'd2
    } arb_state_t;

    // Loader wait cycles before it is promoted over the CPU.
    localparam int DEFAULT_MAX_WAIT = 4;

    // Wide enough for MAX_WAIT up to 15.
    localparam int WAIT_W = 4;

    // Byte address to word address; callers keep the low ADDR_W bits so
    // out-of-range addresses wrap around the RAM.
    function automatic logic [29:0] word_of(input logic [31:0] byte_addr);
        return byte_addr[31:2];
    endfunction

endpackage

// File: rtl/data_mem_arbiter_starve_counter.sv
// Saturating wait counter for the loader. It raises force_pri once the
// loader has waited MAX_WAIT cycles without being acknowledged.
import data_mem_arbiter_pkg::*;

module starve_counter #(
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inc,
    input  logic              clr,
    output logic [WAIT_W-1:0] wait_cnt,
    output logic              force_pri
);

    localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] cnt_reg;

    // Count waiting cycles, clear on ack or when the request goes away, hold at MAX_CNT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != MAX_CNT)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign wait_cnt  = cnt_reg;
    assign force_pri = (cnt_reg == MAX_CNT);

endmodule

// File: rtl/data_mem_arbiter.sv
// Single-port data RAM arbiter between the CPU MEM stage and the UART loader.
// The CPU has fixed priority unless the loader has starved for MAX_WAIT
// cycles or loader-exclusive mode (uart_on) locks the CPU out. Grants are
// decided combinationally in IDLE so the access issues in the same cycle;
// a read spends one extra cycle in CPU_RD/LDR_RD to collect mem_rdata.
import data_mem_arbiter_pkg::*;

module data_mem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_on,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [31:0]       ldr_addr,
    input  logic [31:0]       ldr_wdata,
    output logic              ldr_ack,
    output logic              ldr_rvalid,
    output logic [31:0]       ldr_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    arb_state_t        state;
    logic [31:0]       ldr_rdata_reg;
    logic [WAIT_W-1:0] wait_cnt;
    logic              force_pri;
    logic              cpu_ok;
    logic              ldr_grant;
    logic              cpu_grant;
    logic [29:0]       sel_word;
    logic              unused_sig;

    starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk       (clk),
        .reset     (reset),
        .inc       (ldr_req & ~ldr_ack),
        .clr       (~ldr_req | ldr_ack),
        .wait_cnt  (wait_cnt),
        .force_pri (force_pri)
    );

    // Grant decision: only in IDLE; the loader wins when the CPU cannot or when it has starved.
    always_comb begin
        cpu_ok    = cpu_req & ~uart_on;
        ldr_grant = (state == IDLE) & ldr_req & (~cpu_ok | force_pri);
        cpu_grant = (state == IDLE) & cpu_ok & ~ldr_grant;
    end

    // RAM port mux; everything is forced low while reset is held so a
    // reset mid-transaction takes the bus down immediately.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        sel_word  = '0;
        mem_wdata = '0;
        if (reset) begin
            if (ldr_grant) begin
                mem_en    = 1'b1;
                mem_we    = ldr_we;
                sel_word  = word_of(ldr_addr);
                mem_wdata = ldr_wdata;
            end else if (cpu_grant) begin
                mem_en    = 1'b1;
                mem_we    = cpu_we;
                sel_word  = word_of(cpu_addr);
                mem_wdata = cpu_wdata;
            end
        end
    end

    assign mem_addr = sel_word[ADDR_W-1:0];

    // Word bits above the RAM size are dropped on purpose (address wraps).
    assign unused_sig = ^{sel_word[29:ADDR_W], wait_cnt};

    // Requester-side outputs. A CPU request stalls unless it is a granted
    // write; in CPU_RD the read completes and the stall drops. cpu_rdata is
    // only presented in CPU_RD so nothing stale leaks out elsewhere.
    always_comb begin
        cpu_stall  = 1'b0;
        cpu_rdata  = '0;
        ldr_ack    = 1'b0;
        ldr_rvalid = 1'b0;
        ldr_rdata  = '0;
        if (reset) begin
            ldr_ack   = ldr_grant;
            ldr_rdata = ldr_rdata_reg;
            case (state)
                IDLE: begin
                    cpu_stall = cpu_req & (~cpu_grant | ~cpu_we);
                end
                CPU_RD: begin
                    cpu_rdata = mem_rdata;
                end
                LDR_RD: begin
                    cpu_stall  = cpu_req;
                    ldr_rvalid = 1'b1;
                    ldr_rdata  = mem_rdata;
                end
                default: begin
                    cpu_stall = 1'b0;
                end
            endcase
        end
    end

    // Arbiter FSM: reads park for one cycle in a *_RD state, writes stay in IDLE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (ldr_grant && !ldr_we) begin
                        state <= LDR_RD;
                    end else if (cpu_grant && !cpu_we) begin
                        state <= CPU_RD;
                    end
                end
                CPU_RD:  state <= IDLE;
                LDR_RD:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Hold the last loader read word until the next loader read completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ldr_rdata_reg <= '0;
        end else if (state == LDR_RD) begin
            ldr_rdata_reg <= mem_rdata;
        end
    end

endmodule
